accel_sketch_hex_display_driver: RTL and testbench

//  Consumes the 24-bit word from the HEX PIO and drives six 7-segment digits (HEX0..HEX5).
//  Hex mode shows raw nibbles; decimal mode converts value via iterative double-dabble.

---
 rtl/accel_sketch_hex_display_driver.sv | 195 +++++++++++++++++++
 tb/tb_accel_sketch_hex_display_driver.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_sketch_hex_display_driver.sv
// Six-digit 7-segment driver for the HEX PIO word.
// Hex or double-dabble decimal, with blanking, overflow dashes and blink.
module accel_sketch_hex_display_driver #(
  parameter int unsigned BLINK_DIV  = 25000000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] value_in,
  input  logic        dec_mode,
  input  logic        blank_lz,
  input  logic        blink_en,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic        busy,
  output logic        conv_done
);

  localparam int unsigned CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CMAX = CW'(BLINK_DIV - 1);
  localparam logic [6:0] OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_COMMIT
  } state_e;

  state_e          state_q;
  logic [24:0]     src_q;
  logic [24:0]     last_q;
  logic [24:0]     work_q;
  logic [4:0]      iter_q;
  logic [23:0]     bcd_q;
  logic [19:0]     bin_q;
  logic [23:0]     digits_q;
  logic            ovfw_q;
  logic            ovf_q;
  logic            busy_q;
  logic            done_q;
  logic [CW-1:0]   cnt_q;
  logic            phase_q;
  logic [5:0][6:0] seg_q;
  logic [5:0][6:0] seg_d;
  logic [23:0]     adj_d;
  logic [23:0]     shown_d;
  logic            ovf_d;
  logic [5:0]      lz_d;

  function automatic logic [6:0] dec7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  always_comb begin
    adj_d = bcd_q;
    for (int i = 0; i < 6; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // COMMIT forwards the fresh result so the segments update on that edge
  always_comb begin
    logic z;
    shown_d = (state_q == S_COMMIT) ? bcd_q : digits_q;
    ovf_d   = (state_q == S_COMMIT) ? ovfw_q : ovf_q;
    lz_d    = '0;
    z       = 1'b1;
    for (int k = 5; k >= 1; k--) begin
      z = z && (shown_d[4*k +: 4] == 4'd0);
      lz_d[k] = z;
    end
    for (int k = 0; k < 6; k++) begin
      seg_d[k] = dec7(shown_d[4*k +: 4]);
      if (blank_lz && lz_d[k]) seg_d[k] = 7'h00;
      if (ovf_d) seg_d[k] = 7'h40;
      if (blink_en && phase_q) seg_d[k] = 7'h00;
      if (ACTIVE_LOW) seg_d[k] = ~seg_d[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      last_q   <= '0;
      work_q   <= '0;
      iter_q   <= '0;
      bcd_q    <= '0;
      bin_q    <= '0;
      digits_q <= '0;
      ovfw_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      src_q  <= {dec_mode, value_in};
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (src_q != last_q) begin
            work_q  <= src_q;
            last_q  <= src_q;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!work_q[24]) begin
            bcd_q   <= work_q[23:0];
            ovfw_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_COMMIT;
          end else if (work_q[23:0] > 24'd999999) begin
            ovfw_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_COMMIT;
          end else begin
            ovfw_q  <= 1'b0;
            bcd_q   <= '0;
            bin_q   <= work_q[19:0];
            iter_q  <= '0;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {bcd_q, bin_q} <= {adj_d[22:0], bin_q, 1'b0};
          iter_q <= iter_q + 5'd1;
          if (iter_q == 5'd19) begin
            done_q  <= 1'b1;
            state_q <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          digits_q <= bcd_q;
          ovf_q    <= ovfw_q;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == CMAX) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) seg_q <= {6{OFF}};
    else          seg_q <= seg_d;
  end

  assign hex0      = seg_q[0];
  assign hex1      = seg_q[1];
  assign hex2      = seg_q[2];
  assign hex3      = seg_q[3];
  assign hex4      = seg_q[4];
  assign hex5      = seg_q[5];
  assign busy      = busy_q;
  assign conv_done = done_q;

endmodule

// File: tb/tb_accel_sketch_hex_display_driver.sv
// Bench for the hex display driver: scoreboard of committed results
// plus direct latency, blanking, overflow, blink and reset checks.
module tb_accel_sketch_hex_display_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] value_in;
  logic        dec_mode;
  logic        blank_lz;
  logic        blink_en;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic        busy;
  logic        conv_done;
  logic [41:0] hexcat;

  int n_run  = 0;
  int n_fail = 0;
  int n_pulse = 0;
  logic [41:0] sb_q[$];

  accel_sketch_hex_display_driver #(
    .BLINK_DIV (4),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .value_in (value_in),
    .dec_mode (dec_mode),
    .blank_lz (blank_lz),
    .blink_en (blink_en),
    .hex0     (hex0),
    .hex1     (hex1),
    .hex2     (hex2),
    .hex3     (hex3),
    .hex4     (hex4),
    .hex5     (hex5),
    .busy     (busy),
    .conv_done(conv_done)
  );

  always #5 clk = ~clk;
  assign hexcat = {hex5, hex4, hex3, hex2, hex1, hex0};

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // active-low expected segments for a whole display word
  function automatic logic [41:0] model(logic [23:0] v, logic d, logic blz);
    logic [6:0] tbl [16];
    logic [3:0] dg [6];
    logic [41:0] r;
    logic [6:0] s;
    logic lead;
    int unsigned x;
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    if (d && v > 24'd999999) return {6{7'h3F}};
    x = v;
    for (int i = 0; i < 6; i++) begin
      if (d) begin
        dg[i] = 4'(x % 10);
        x = x / 10;
      end else begin
        dg[i] = v[4*i +: 4];
      end
    end
    lead = 1'b1;
    r = '0;
    for (int i = 5; i >= 0; i--) begin
      s = tbl[dg[i]];
      if (blz && lead && i > 0 && dg[i] == 4'd0) s = 7'h00;
      else lead = 1'b0;
      r[7*i +: 7] = ~s;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [23:0] v, logic d, logic push);
    @(negedge clk);
    value_in = v;
    dec_mode = d;
    if (push) sb_q.push_back(model(v, d, blank_lz));
  endtask

  task automatic wait_quiet();
    int lo = 0;
    int k = 0;
    while (lo < 3 && k < 300) begin
      step();
      k++;
      lo = busy ? 0 : lo + 1;
    end
    if (lo < 3) check("quiet_timeout", 0, 1);
  endtask

  // scoreboard: conv_done seen, compare on the following negedge
  initial begin
    logic pend = 1'b0;
    logic [41:0] e;
    forever begin
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        if (sb_q.size() == 0) begin
          check("sb_underflow", 0, 1);
        end else begin
          e = sb_q.pop_front();
          check("sb_commit", hexcat, e);
        end
      end
      if (conv_done) begin
        pend = 1'b1;
        n_pulse++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [41:0] old;
    logic changed;
    int nb;
    int p0;
    logic s [24];
    int t;
    logic [7:0] got8;

    reset_n  = 1'b0;
    value_in = '0;
    dec_mode = 1'b0;
    blank_lz = 1'b0;
    blink_en = 1'b0;
    repeat (3) step();
    check("rst_hex", hexcat, {6{7'h7F}});
    check("rst_busy", busy, 0);
    check("rst_done", conv_done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("post_rst_zero", hexcat, {6{7'h40}});
    wait_quiet();

    // 1: hex mode
    old = hexcat;
    p0 = n_pulse;
    nb = 0;
    changed = 1'b0;
    drive(24'h12AB3F, 1'b0, 1'b1);
    for (int e = 1; e <= 6; e++) begin
      step();
      if (busy) nb++;
      if (e < 4 && hexcat !== old) changed = 1'b1;
      if (e == 4)
        check("t1_lat4", hexcat,
              ~{7'h06, 7'h5B, 7'h77, 7'h7C, 7'h4F, 7'h71} & {6{7'h7F}});
    end
    check("t1_hold", changed, 0);
    check("t1_busy2", nb, 2);
    wait_quiet();
    check("t1_pulse", n_pulse - p0, 1);

    // 2: decimal
    old = hexcat;
    changed = 1'b0;
    drive(24'd123456, 1'b1, 1'b1);
    for (int e = 1; e <= 24; e++) begin
      step();
      if (e < 24 && hexcat !== old) changed = 1'b1;
      if (e == 24)
        check("t2_lat24", hexcat,
              ~{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D} & {6{7'h7F}});
    end
    check("t2_hold", changed, 0);
    wait_quiet();

    // 3: leading-zero blanking
    @(negedge clk);
    blank_lz = 1'b1;
    drive(24'd7, 1'b1, 1'b1);
    wait_quiet();
    check("t3_seven", hexcat, {{5{7'h7F}}, 7'h78});
    drive(24'd0, 1'b1, 1'b1);
    wait_quiet();
    check("t3_zero", hexcat, {{5{7'h7F}}, 7'h40});

    // 4: overflow and max
    @(negedge clk);
    blank_lz = 1'b0;
    repeat (3) step();
    old = hexcat;
    changed = 1'b0;
    drive(24'd1000000, 1'b1, 1'b1);
    for (int e = 1; e <= 4; e++) begin
      step();
      if (e < 4 && hexcat !== old) changed = 1'b1;
      if (e == 4) check("t4_dash", hexcat, {6{7'h3F}});
    end
    check("t4_hold", changed, 0);
    wait_quiet();
    drive(24'd999999, 1'b1, 1'b1);
    wait_quiet();
    check("t4_nines", hexcat, {6{7'h10}});

    // 5: change during SHIFT is deferred, then shown
    p0 = n_pulse;
    drive(24'd111111, 1'b1, 1'b1);
    repeat (7) step();
    drive(24'd222222, 1'b1, 1'b1);
    wait_quiet();
    check("t5_pulses", n_pulse - p0, 2);
    check("t5_final", hexcat, model(24'd222222, 1'b1, 1'b0));

    // 6a: blink 4 off / 4 on
    @(negedge clk);
    blink_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      s[i] = (hexcat === {6{7'h7F}});
    end
    t = 0;
    for (int i = 1; i < 9; i++)
      if (t == 0 && s[i] != s[i-1]) t = i;
    if (t == 0) begin
      check("t6_blink_edge", 0, 1);
    end else begin
      for (int j = 0; j < 8; j++) got8[7-j] = s[t+j];
      check("t6_blink", got8, s[t] ? 8'b11110000 : 8'b00001111);
    end
    @(negedge clk);
    blink_en = 1'b0;
    wait_quiet();
    check("t6_unblink", hexcat, model(24'd222222, 1'b1, 1'b0));

    // 6b: reset mid-SHIFT
    p0 = n_pulse;
    drive(24'd654321, 1'b1, 1'b0);
    repeat (8) step();
    reset_n  = 1'b0;
    value_in = '0;
    dec_mode = 1'b0;
    #1;
    check("t6_rst_hex", hexcat, {6{7'h7F}});
    check("t6_rst_busy", busy, 0);
    repeat (2) step();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("t6_rel_hex", hexcat, {6{7'h40}});
    wait_quiet();
    check("t6_no_pulse", n_pulse - p0, 0);

    check("sb_left", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
